// File: rtl/seq_mac_pkg.sv
// Shared types and width helpers for the seq_mac multiply-accumulate stage.
// Optional build macro SEQ_MAC_SIGNED_EN is consumed by seq_mac.sv, not here.
package seq_mac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ACC  = 2'd2
    } state_t;

    function automatic int acc_w(input int width, input int guard);
        return 2 * width + guard;
    endfunction

    // Ceiling log2, floored at 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mac_reg.sv
// N-bit storage register with load enable and asynchronous active-high reset.
module mac_reg #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    // Hold value unless enabled; reset clears immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= {N{1'b0}};
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/seq_mac.sv
// Sequential shift-add multiplier feeding a guarded running accumulator.
// Build macro SEQ_MAC_SIGNED_EN selects two's complement Booth mode.
module seq_mac
    import seq_mac_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GUARD = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               clear_acc,
    input  logic [WIDTH-1:0]                   a,
    input  logic [WIDTH-1:0]                   b,
    output logic                               busy,
    output logic                               done,
    output logic [acc_w(WIDTH, GUARD)-1:0]     acc,
    output logic                               ovf
);

    localparam int ACC_W  = acc_w(WIDTH, GUARD);
    localparam int PROD_W = 2 * WIDTH;
    localparam int CNT_W  = clog2(WIDTH);
`ifdef SEQ_MAC_SIGNED_EN
    localparam int MPL_W  = WIDTH + 1;   // low bit holds the previous Booth bit
`else
    localparam int MPL_W  = WIDTH;
`endif
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t              state_r, state_s;
    logic                accept_s, clear_s, run_s, acc_step_s;
    logic                opnd_en_s, acc_en_s, ovf_step_s;
    logic [WIDTH-1:0]    mcand_r;
    logic [MPL_W-1:0]    mpl_r, mpl_d_s;
    logic [PROD_W-1:0]   prod_r, prod_d_s;
    logic [WIDTH:0]      step_sum_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [ACC_W-1:0]    prod_ext_s, acc_sum_s, acc_d_s;
    logic                busy_r, done_r, ovf_r;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and per-state strobes.
    always_comb begin
        state_s    = state_r;
        accept_s   = 1'b0;
        clear_s    = 1'b0;
        run_s      = 1'b0;
        acc_step_s = 1'b0;
        case (state_r)
            IDLE: begin
                clear_s = clear_acc;
                if (start) begin
                    accept_s = 1'b1;
                    state_s  = RUN;
                end else begin
                    state_s  = IDLE;
                end
            end
            RUN: begin
                run_s = 1'b1;
                if (cnt_r == CNT_LAST) begin
                    state_s = ACC;
                end else begin
                    state_s = RUN;
                end
            end
            ACC: begin
                acc_step_s = 1'b1;
                state_s    = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Bit counter and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r  <= {CNT_W{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            busy_r <= (state_s != IDLE);
            done_r <= acc_step_s;
            if (accept_s) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (run_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            if (clear_s) begin
                ovf_r <= 1'b0;
            end else if (acc_step_s) begin
                ovf_r <= ovf_r | ovf_step_s;
            end
        end
    end

    // One multiplier step: add into the upper half, then shift product right.
    always_comb begin
`ifdef SEQ_MAC_SIGNED_EN
        case (mpl_r[1:0])
            2'b01:   step_sum_s = {prod_r[PROD_W-1], prod_r[PROD_W-1:WIDTH]}
                                + {mcand_r[WIDTH-1], mcand_r};
            2'b10:   step_sum_s = {prod_r[PROD_W-1], prod_r[PROD_W-1:WIDTH]}
                                - {mcand_r[WIDTH-1], mcand_r};
            default: step_sum_s = {prod_r[PROD_W-1], prod_r[PROD_W-1:WIDTH]};
        endcase
`else
        if (mpl_r[0]) begin
            step_sum_s = {1'b0, prod_r[PROD_W-1:WIDTH]} + {1'b0, mcand_r};
        end else begin
            step_sum_s = {1'b0, prod_r[PROD_W-1:WIDTH]};
        end
`endif
        if (accept_s) begin
            prod_d_s = {PROD_W{1'b0}};
`ifdef SEQ_MAC_SIGNED_EN
            mpl_d_s  = {b, 1'b0};
`else
            mpl_d_s  = b;
`endif
        end else begin
            prod_d_s = {step_sum_s, prod_r[WIDTH-1:1]};
            mpl_d_s  = {1'b0, mpl_r[MPL_W-1:1]};
        end
    end

    // Accumulator adder and overflow detection.
    always_comb begin
`ifdef SEQ_MAC_SIGNED_EN
        prod_ext_s = {{GUARD{prod_r[PROD_W-1]}}, prod_r};
        acc_sum_s  = acc + prod_ext_s;
        ovf_step_s = (acc[ACC_W-1] == prod_ext_s[ACC_W-1]) &&
                     (acc_sum_s[ACC_W-1] != acc[ACC_W-1]);
`else
        prod_ext_s = {{GUARD{1'b0}}, prod_r};
        {ovf_step_s, acc_sum_s} = {1'b0, acc} + {1'b0, prod_ext_s};
`endif
        if (acc_step_s) begin
            acc_d_s = acc_sum_s;
        end else begin
            acc_d_s = {ACC_W{1'b0}};
        end
    end

    assign opnd_en_s = accept_s | run_s;
    assign acc_en_s  = clear_s | acc_step_s;

    mac_reg #(.N(WIDTH))  u_mcand (.clk(clk), .reset(reset), .en(accept_s),  .d(a),        .q(mcand_r));
    mac_reg #(.N(MPL_W))  u_mpl   (.clk(clk), .reset(reset), .en(opnd_en_s), .d(mpl_d_s),  .q(mpl_r));
    mac_reg #(.N(PROD_W)) u_prod  (.clk(clk), .reset(reset), .en(opnd_en_s), .d(prod_d_s), .q(prod_r));
    mac_reg #(.N(ACC_W))  u_acc   (.clk(clk), .reset(reset), .en(acc_en_s),  .d(acc_d_s),  .q(acc));

    assign busy = busy_r;
    assign done = done_r;
    assign ovf  = ovf_r;

endmodule
